// File: rtl/seg_disp_pkg.sv
// Shared constants and helpers for the seg_disp_scan 7-segment scanner.
package seg_disp_pkg;

    localparam int SEG_W = 8;

    // Standard a..g encoding, bit0 = a ... bit6 = g.
    localparam logic [6:0] HEX2SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        return HEX2SEG[nib];
    endfunction

    function automatic logic [SEG_W-1:0] seg_pol(input logic [SEG_W-1:0] v, input logic active_low);
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/seg_disp_scan_hex_decode.sv
// Combinational nibble to 7-segment (g..a) decoder.
module seg_hex_decode
    import seg_disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex2seg(nibble_i);

endmodule

// File: rtl/seg_disp_scan.sv
// Multiplexed N-digit 7-segment scanner with frame shadowing, 16-level PWM and dead time.
// Optional blinking is built when SEG_DISP_BLINK_EN is defined.
module seg_disp_scan
    import seg_disp_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 16384,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int BLINK_FRAMES   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     en_i,
    input  logic                  mode_i,
    input  logic [4*DIGITS-1:0]   data_text_i,
    input  logic [8*DIGITS-1:0]   data_graphic_i,
    input  logic [DIGITS-1:0]     dot_i,
    input  logic [3:0]            bright_i,
`ifdef SEG_DISP_BLINK_EN
    input  logic [DIGITS-1:0]     blink_i,
`endif
    output logic [SEG_W-1:0]      segment_o,
    output logic [DIGITS-1:0]     anode_o,
    output logic                  frame_start_o
);

    localparam int   STEP    = SCAN_DIV / 16;
    localparam int   SUB_W   = (STEP > 1) ? $clog2(STEP) : 1;
    localparam int   IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic AN_LOW  = (AN_ACTIVE_LOW != 0);
    localparam logic SEG_LOW = (SEG_ACTIVE_LOW != 0);

    // slot_cnt is kept split as lvl*STEP + sub so the brightness level needs no divider.
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [3:0]       lvl_q, lvl_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             init_q;
    logic             slot_end, frame_wrap, load, slot_zero, blanked, lit;

    logic [DIGITS-1:0]   en_s_q, dot_s_q;
    logic                mode_s_q;
    logic [4*DIGITS-1:0] text_s_q;
    logic [8*DIGITS-1:0] gfx_s_q;
    logic [3:0]          bright_s_q;

    logic [SEG_W-1:0]  segment_q, segment_d, seg_raw;
    logic [DIGITS-1:0] anode_q, anode_d, onehot;
    logic              frame_start_q, frame_start_d;
    logic [6:0]        dec_seg;

    logic [3:0] nib_arr [DIGITS];
    logic [7:0] gfx_arr [DIGITS];

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign nib_arr[gi] = text_s_q[gi*4 +: 4];
        assign gfx_arr[gi] = gfx_s_q[gi*8 +: 8];
        assign onehot[gi]  = (idx_q == IDX_W'(gi));
    end

    seg_hex_decode u_dec (
        .nibble_i (nib_arr[idx_q]),
        .seg_o    (dec_seg)
    );

    assign slot_end   = (lvl_q == 4'd15) && (sub_q == SUB_W'(STEP - 1));
    assign frame_wrap = slot_end && (idx_q == IDX_W'(DIGITS - 1));
    assign load       = init_q || frame_wrap;
    assign slot_zero  = (lvl_q == 4'd0) && (sub_q == '0);

    always_comb begin
        sub_d = sub_q + 1'b1;
        lvl_d = lvl_q;
        idx_d = idx_q;
        if (sub_q == SUB_W'(STEP - 1)) begin
            sub_d = '0;
            lvl_d = lvl_q + 1'b1;
        end
        if (slot_end) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

`ifdef SEG_DISP_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic              phase_q, phase_d;
    logic [DIGITS-1:0] blink_s_q;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (frame_wrap) begin
            if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
            blink_s_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
            if (load) blink_s_q <= blink_i;
        end
    end

    assign blanked = phase_q && blink_s_q[idx_q];
`else
    // BLINK_FRAMES stays on the interface so both builds share one parameter list.
    assign blanked = (BLINK_FRAMES < 0);
`endif

    always_comb begin
        lit           = en_s_q[idx_q] && !slot_zero && (lvl_q <= bright_s_q) && !blanked;
        seg_raw       = mode_s_q ? gfx_arr[idx_q] : {dot_s_q[idx_q], dec_seg};
        anode_d       = lit ? (onehot ^ {DIGITS{AN_LOW}}) : {DIGITS{AN_LOW}};
        segment_d     = seg_pol(lit ? seg_raw : '0, SEG_LOW);
        frame_start_d = load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q         <= '0;
            lvl_q         <= '0;
            idx_q         <= '0;
            init_q        <= 1'b1;
            en_s_q        <= '0;
            dot_s_q       <= '0;
            mode_s_q      <= 1'b0;
            text_s_q      <= '0;
            gfx_s_q       <= '0;
            bright_s_q    <= '0;
            anode_q       <= {DIGITS{AN_LOW}};
            segment_q     <= {SEG_W{SEG_LOW}};
            frame_start_q <= 1'b0;
        end else begin
            sub_q         <= sub_d;
            lvl_q         <= lvl_d;
            idx_q         <= idx_d;
            init_q        <= 1'b0;
            anode_q       <= anode_d;
            segment_q     <= segment_d;
            frame_start_q <= frame_start_d;
            if (load) begin
                en_s_q     <= en_i;
                dot_s_q    <= dot_i;
                mode_s_q   <= mode_i;
                text_s_q   <= data_text_i;
                gfx_s_q    <= data_graphic_i;
                bright_s_q <= bright_i;
            end
        end
    end

    assign segment_o     = segment_q;
    assign anode_o       = anode_q;
    assign frame_start_o = frame_start_q;

endmodule
